// File: rtl/zap_thumb_fetch_sequencer.sv
// ============================================================================
// Module  : zap_thumb_fetch_sequencer
// Brief   : Splits I-cache fetch words into ARM words or Thumb halfwords with
//           per-instruction PC, and masks IRQ/FIQ across Thumb BL pairs.
// Option  : ZAP_THUMB_SEQ_STATS_EN adds issue / masked-interrupt counters.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_thumb_fetch_sequencer #(
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [31:0]           i_word,
    input  logic [31:0]           i_word_pc,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic                  i_cpsr_t,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_irq,
    input  logic                  i_fiq,
    output logic [31:0]           o_instruction,
    output logic                  o_instruction_valid,
    output logic [31:0]           o_pc,
    output logic                  o_irq,
    output logic                  o_fiq
`ifdef ZAP_THUMB_SEQ_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] o_stat_issued,
    output logic [STAT_WIDTH-1:0] o_stat_irq_masked
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_ARM   = 2'd3
    } state_t;

    localparam logic [4:0] c_BL_PREFIX = 5'b11110;

    state_t      state_q, state_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] wpc_q, wpc_d;
    logic        wt_q, wt_d;
    logic        bl_pending_q, bl_pending_d;

    logic        w_accept;
    logic        w_issue;
    logic        w_prefix;
    state_t      w_new_state;
    logic        w_unused_ok;

    // ------------------------------------------------------------------
    // Output datapath: purely a function of the held word and its state.
    // ------------------------------------------------------------------
    always_comb begin
        o_instruction = 32'd0;
        o_pc          = 32'd0;
        case (state_q)
            S_LO: begin
                o_instruction = {16'd0, wbuf_q[15:0]};
                o_pc          = {wpc_q[31:2], 2'b00};
            end
            S_HI: begin
                o_instruction = {16'd0, wbuf_q[31:16]};
                o_pc          = {wpc_q[31:2], 2'b10};
            end
            S_ARM: begin
                o_instruction = wbuf_q;
                o_pc          = {wpc_q[31:2], 2'b00};
            end
            default: begin
                o_instruction = 32'd0;
                o_pc          = 32'd0;
            end
        endcase
    end

    assign o_instruction_valid = (state_q != S_EMPTY);

    // Ready while draining the last slot lets the next word land with no bubble.
    assign o_word_ready = i_reset_n & ~i_flush &
                          ((state_q == S_EMPTY) |
                           (((state_q == S_HI) | (state_q == S_ARM)) & ~i_stall));

    assign w_accept = i_word_valid & o_word_ready;
    assign w_issue  = o_instruction_valid & ~i_stall;

    assign w_prefix = wt_q & ((state_q == S_LO) | (state_q == S_HI)) &
                      (o_instruction[15:11] == c_BL_PREFIX);

    assign o_irq = i_irq & o_instruction_valid & ~w_prefix & ~bl_pending_q;
    assign o_fiq = i_fiq & o_instruction_valid & ~w_prefix & ~bl_pending_q;

    always_comb begin
        w_new_state = S_LO;
        if (!i_cpsr_t) begin
            w_new_state = S_ARM;
        end else if (i_word_pc[1]) begin
            w_new_state = S_HI;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides every other event.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wbuf_d       = wbuf_q;
        wpc_d        = wpc_q;
        wt_d         = wt_q;
        bl_pending_d = bl_pending_q;

        if (i_flush) begin
            state_d      = S_EMPTY;
            bl_pending_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        state_d = w_new_state;
                    end
                end
                S_LO: begin
                    if (w_issue) begin
                        state_d = S_HI;
                    end
                end
                S_HI, S_ARM: begin
                    if (w_issue) begin
                        state_d = w_accept ? w_new_state : S_EMPTY;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase

            if (w_issue) begin
                bl_pending_d = w_prefix;
            end

            if (w_accept) begin
                wbuf_d = i_word;
                wpc_d  = i_word_pc;
                wt_d   = i_cpsr_t;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_EMPTY;
            wbuf_q       <= 32'd0;
            wpc_q        <= 32'd0;
            wt_q         <= 1'b0;
            bl_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbuf_q       <= wbuf_d;
            wpc_q        <= wpc_d;
            wt_q         <= wt_d;
            bl_pending_q <= bl_pending_d;
        end
    end

`ifdef ZAP_THUMB_SEQ_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: free-running, wrapping, deliberately blind to flush.
    // ------------------------------------------------------------------
    logic [STAT_WIDTH-1:0] stat_issued_q, stat_issued_d;
    logic [STAT_WIDTH-1:0] stat_masked_q, stat_masked_d;
    logic                  w_masked;

    assign w_masked = (i_irq | i_fiq) & o_instruction_valid & ~o_irq & ~o_fiq;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_masked_d = stat_masked_q;
        if (w_issue) begin
            stat_issued_d = stat_issued_q + STAT_WIDTH'(1);
        end
        if (w_masked) begin
            stat_masked_d = stat_masked_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stat_issued_q <= '0;
            stat_masked_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_masked_q <= stat_masked_d;
        end
    end

    assign o_stat_issued     = stat_issued_q;
    assign o_stat_irq_masked = stat_masked_q;
`endif

    // The fetch byte offset is regenerated from state, so wpc[1:0] is never read back.
    assign w_unused_ok = ^{wpc_q[1:0], i_word_pc[0], 1'(STAT_WIDTH % 2)};

endmodule

`default_nettype wire

// File: doc/zap_thumb_fetch_sequencer.md
Name: zap_thumb_fetch_sequencer

Overview:
Sits between the I-cache and the Thumb-to-ARM decoder. Accepts 32-bit fetch words and issues them downstream one instruction at a time with a PC per instruction:
- ARM mode: one whole word per issue.
- Thumb mode: two 16-bit halfwords per word, starting at the correct half for the fetch PC.
- Keeps a BL prefix/suffix pair uninterruptible by masking IRQ/FIQ across the pair.
- Handles downstream stall and pipeline flush.

Parameters:
STAT_WIDTH, 32, width of the statistics counters (used only with the optional feature).

Ports:
i_clk  input  1  clock, rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_word  input  32  fetch word from I-cache.
i_word_pc  input  32  byte address of the fetch (Thumb fetches may have bit 1 set).
i_word_valid  input  1  i_word/i_word_pc valid.
o_word_ready  output  1  sequencer can accept a word this cycle.
i_cpsr_t  input  1  CPSR T bit; sampled when a word is accepted.
i_stall  input  1  decoder cannot take an instruction this cycle.
i_flush  input  1  synchronous pipeline flush (branch/exception).
i_irq  input  1  raw IRQ request.
i_fiq  input  1  raw FIQ request.
o_instruction  output  32  ARM word, or Thumb halfword in [15:0] with [31:16]=0.
o_instruction_valid  output  1  o_instruction valid.
o_pc  output  32  address of o_instruction.
o_irq  output  1  IRQ attached to the current instruction.
o_fiq  output  1  FIQ attached to the current instruction.

Behaviour:
- Storage: word buffer wbuf[31:0], wpc[31:0], wt (latched T bit), bl_pending, state in {EMPTY, LO, HI, ARM}.
- Definitions:
  - accept = i_word_valid & o_word_ready.
  - issue = o_instruction_valid & ~i_stall.
- o_word_ready = i_reset_n & ~i_flush & (state==EMPTY | ((state==HI | state==ARM) & ~i_stall)). This gives back-to-back streaming with no bubble.
- On accept: wbuf<=i_word, wpc<=i_word_pc, wt<=i_cpsr_t. Next state:
  - ARM if i_cpsr_t=0;
  - HI if i_cpsr_t=1 and i_word_pc[1]=1;
  - LO otherwise.
- Transitions:
  - EMPTY: accept → LO/HI/ARM.
  - LO: issue → HI; otherwise hold.
  - HI / ARM: issue with accept → new word state; issue without accept → EMPTY; no issue → hold.
- Flush has top priority over every other event: state<=EMPTY, bl_pending<=0. No word is accepted in the flush cycle. Any instruction presented in that cycle is discarded; the decoder ignores it.
- Outputs are combinational from the buffer; latency is one cycle from accept to o_instruction_valid.
  - o_instruction_valid = (state!=EMPTY).
  - LO: o_instruction={16'd0,wbuf[15:0]}, o_pc={wpc[31:2],2'b00}.
  - HI: o_instruction={16'd0,wbuf[31:16]}, o_pc={wpc[31:2],2'b10}.
  - ARM: o_instruction=wbuf, o_pc={wpc[31:2],2'b00}.
  - EMPTY: o_instruction=0, o_pc=0.
- BL pairing (Thumb only):
  - prefix = valid Thumb halfword with [15:11]=5'b11110.
  - On issue of a prefix: bl_pending<=1. On issue of any other instruction: bl_pending<=0.
  - o_irq = i_irq & o_instruction_valid & ~prefix & ~bl_pending. o_fiq follows the same rule with i_fiq.
  - Result: neither half of a BL pair carries an interrupt. A pending interrupt attaches to the first instruction after the suffix.
  - A prefix at HI followed by a suffix at LO of the next word stays paired across the word boundary.
  - A stall between prefix and suffix keeps the mask in place.
- Mode changes take effect only via flush plus refetch. wt is never updated mid-word.
- Reset (asynchronous assert, synchronous deassert by the system):
  - state=EMPTY, wbuf=0, wpc=0, wt=0, bl_pending=0.
  - All outputs 0, including o_word_ready while reset is asserted.
  - Reset mid-pair drops the pair silently.

Optional Feature:
ZAP_THUMB_SEQ_STATS_EN
- Defined: adds output ports o_stat_issued[STAT_WIDTH-1:0] (count of issue events) and o_stat_irq_masked[STAT_WIDTH-1:0] (count of cycles where (i_irq|i_fiq) & o_instruction_valid but both o_irq and o_fiq are 0 due to BL masking). Both counters wrap modulo 2^STAT_WIDTH, reset to 0, and are unaffected by flush.
- Undefined: these ports and counters do not exist. Base behaviour is identical.

Test Plan:
- Thumb stream: T=1, words 0x2001_2102 @0x100 then 0x3301_3202 @0x104, no stall → issues 0x2102@0x100, 0x2001@0x102, 0x3202@0x104, 0x3301@0x106 on 4 consecutive cycles; o_word_ready high in each HI cycle.
- Odd-halfword entry: T=1, word 0xE7FE_BF00 @0x202 → single issue 0xE7FE@0x202, then EMPTY.
- BL across a word boundary with IRQ: word @0x300 with [31:16]=0xF000, next word [15:0]=0xF802, i_irq held high → o_irq=0 on both halves; o_irq=1 on the next instruction @0x306.
- Stall and flush: ARM word 0xE3A0_0001 @0x400, i_stall=1 for 3 cycles then i_flush → output held stable 3 cycles, state EMPTY after flush, no word accepted in the flush cycle.
- Reset mid-LO: assert i_reset_n=0 asynchronously while in LO with bl_pending=1 → all outputs 0 immediately; after release, first word issues normally with o_irq unmasked.
- With ZAP_THUMB_SEQ_STATS_EN and STAT_WIDTH=4: 17 issues → o_stat_issued=1 (wrap).
